// File: rtl/fpga2hps_pkg.sv
// Shared register map for the FPGA-to-HPS return FIFO: word addresses and
// bit positions inside the STATUS and CONTROL registers.
package fpga2hps_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  // STATUS layout: occupancy in [7:0], then flags
  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_EMPTY   = 8;
  localparam int STAT_FULL    = 9;
  localparam int STAT_OVF     = 10;
  localparam int STAT_UNF     = 11;

  // CONTROL layout: write-one actions
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_CLR_UNF = 2;

endpackage

// File: rtl/fpga2hps_fifo_sync_fifo.sv
// Small synchronous FIFO: storage array, wrap-around pointers and an
// occupancy counter. Push and pop arrive already qualified by the caller;
// flush overrides both and returns the FIFO to empty.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Storage is never cleared; stale contents are unreachable once pointers reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Next pointer/count: flush beats everything, otherwise push and pop add up.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/fpga2hps_fifo.sv
// Avalon-MM slave returning FPGA-side results to the HPS. FPGA logic pushes
// words with valid/ready; the HPS pops via DATA, polls STATUS and manages
// the FIFO and sticky error flags via CONTROL.
module fpga2hps_fifo
  import fpga2hps_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] D_import,
  input  logic              D_valid,
  output logic              D_ready
);

  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              data_rd, ctrl_wr, flush, push, pop, ovf_set, unf_set;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] status_word;

  // Only the three action bits of CONTROL carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata[DATA_W-1:3];

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (D_import),
    .pop       (pop),
    .flush     (flush),
    .rd_data   (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Decode bus strobes into FIFO actions and flag events; flush suppresses both.
  always_comb begin
    data_rd = read && (address == ADDR_DATA);
    ctrl_wr = write && (address == ADDR_CONTROL);
    flush   = ctrl_wr && writedata[CTRL_FLUSH];
    push    = D_valid && !fifo_full && !flush;
    pop     = data_rd && !fifo_empty && !flush;
    ovf_set = D_valid && fifo_full && !flush;
    unf_set = data_rd && fifo_empty && !flush;
  end

  // STATUS snapshot of the registered state.
  always_comb begin
    status_word = '0;
    status_word[STAT_CNT_LSB +: 8] = 8'(fifo_count);
    status_word[STAT_EMPTY]        = fifo_empty;
    status_word[STAT_FULL]         = fifo_full;
    status_word[STAT_OVF]          = ovf_q;
    status_word[STAT_UNF]          = unf_q;
  end

  // Sticky flags (a same-cycle set beats a clear) and read data selection.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ctrl_wr && writedata[CTRL_CLR_OVF]) ovf_d = 1'b0;
    if (ctrl_wr && writedata[CTRL_CLR_UNF]) unf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    if (unf_set) unf_d = 1'b1;

    readdata_d = readdata_q;
    if (read) begin
      case (address)
        ADDR_DATA:   readdata_d = pop ? fifo_rd_data : '0;
        ADDR_STATUS: readdata_d = status_word;
        default:     readdata_d = '0;
      endcase
    end
  end

  // Flag and read data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign readdata = readdata_q;
  assign D_ready  = !fifo_full;

endmodule
